// File: rtl/riscv_nn_apu_arbiter.sv
// Round-robin arbiter sharing one APU port between several core dispatchers.
// Granted core IDs are queued in order so each returning result reaches its originator.
module riscv_nn_apu_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 96,
  parameter int RESULT_W  = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CORES-1:0]           core_req_i,
  input  logic [NUM_CORES*PAYLOAD_W-1:0] core_payload_i,
  output logic [NUM_CORES-1:0]           core_gnt_o,
  output logic [NUM_CORES-1:0]           core_valid_o,
  output logic [RESULT_W-1:0]            core_result_o,
  output logic                           apu_req_o,
  output logic [PAYLOAD_W-1:0]           apu_payload_o,
  input  logic                           apu_gnt_i,
  input  logic                           apu_valid_i,
  input  logic [RESULT_W-1:0]            apu_result_i,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshakes: a request transfers when req and gnt are both high in the same
  // cycle; once raised toward the APU, a request holds its selection until granted.
  // A result transfers in any cycle apu_valid_i is high; there is no back-pressure.

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  lock_state_e      lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic [IDX_W-1:0] rr_pick, cand, sel, dest;
  logic             rr_hit, full, empty, accept, bypass, push, pop, routed, orphan;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return IDX_W'(s);
  endfunction

  // First requester at or after the round-robin pointer.
  always_comb begin
    rr_hit  = 1'b0;
    rr_pick = rr_q;
    cand    = rr_q;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = wrap_add(rr_q, k);
      if (!rr_hit && core_req_i[cand]) begin
        rr_hit  = 1'b1;
        rr_pick = cand;
      end
    end
  end

  assign sel       = (lock_q == LOCK_HELD) ? lock_idx_q : rr_pick;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign apu_req_o = (|core_req_i) & ~full;
  assign accept    = apu_req_o & apu_gnt_i;

  // A result with nothing queued can only belong to a same-cycle accept.
  assign bypass = apu_valid_i & empty & accept;
  assign orphan = apu_valid_i & empty & ~accept;
  assign routed = apu_valid_i & (~empty | accept);
  assign push   = accept & ~bypass;
  assign pop    = apu_valid_i & ~empty;
  assign dest   = empty ? sel : tag_mem[rd_ptr_q];

  always_comb begin
    apu_payload_o = '0;
    core_gnt_o    = '0;
    core_valid_o  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (sel == IDX_W'(i)) begin
        apu_payload_o = core_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
        core_gnt_o[i] = accept;
      end
      if (dest == IDX_W'(i)) core_valid_o[i] = routed;
    end
  end

  assign core_result_o = apu_result_i;
  assign busy_o        = ~empty;
  assign err_o         = err_q;

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      lock_d = LOCK_IDLE;
    end else if (apu_req_o) begin
      lock_d     = LOCK_HELD;
      lock_idx_d = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= LOCK_IDLE;
      lock_idx_q <= '0;
      rr_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      if (accept) rr_q <= wrap_add(sel, 1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop) count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (orphan) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr_q] <= sel;
  end

endmodule

// File: doc/riscv_nn_apu_arbiter.md
# riscv_nn_apu_arbiter

Shares one APU port between NUM_CORES core-side APU dispatchers. Selects one pending request per cycle by round-robin and forwards its payload to the shared APU. Records the winning core ID in an in-order tag FIFO and routes each returning result back to its originating core. Sits between the per-core dispatchers' req/gnt/valid handshakes and the single shared APU interconnect port.

## Interface
- NUM_CORES, 4: number of requesting cores (2..8).
- DEPTH, 4: maximum outstanding (granted, unreturned) operations; power of two.
- PAYLOAD_W, 96: width of the opaque request payload (operands, op, flags).
- RESULT_W, 32: width of the result returned by the APU.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- core_req_i  in  NUM_CORES  per-core request; held high until granted.
- core_payload_i  in  NUM_CORES×PAYLOAD_W  per-core request payload.
- core_gnt_o  out  NUM_CORES  per-core grant (one-hot or zero).
- core_valid_o  out  NUM_CORES  per-core result valid (one-hot or zero).
- core_result_o  out  RESULT_W  result, broadcast to all cores; qualified by core_valid_o.
- apu_req_o  out  1  request to the shared APU.
- apu_payload_o  out  PAYLOAD_W  payload of the selected core.
- apu_gnt_i  in  1  APU accepts the request this cycle.
- apu_valid_i  in  1  APU returns a result this cycle; results return in acceptance order.
- apu_result_i  in  RESULT_W  returned result.
- busy_o  out  1  at least one operation outstanding.
- err_o  out  1  sticky: a result arrived with no operation outstanding.

## Operation
- State: round-robin pointer rr (0..NUM_CORES-1), lock flag plus locked index, tag FIFO (DEPTH entries of clog2(NUM_CORES) bits) with occupancy count 0..DEPTH, sticky err.
- Selection: if lock is set, sel = locked index. Otherwise sel = the first core with core_req_i high, searching rr, rr+1, … modulo NUM_CORES.
- apu_req_o = (any core_req_i) & (count != DEPTH). apu_payload_o = core_payload_i[sel]. apu_payload_o is don't-care when apu_req_o is low.
- Lock: if apu_req_o & !apu_gnt_i, set lock with index sel. Selection then holds until a grant, even if a higher-priority core raises its request. Lock clears on grant.
- Grant: accept = apu_req_o & apu_gnt_i. core_gnt_o[sel] = accept. On accept, rr <= (sel+1) mod NUM_CORES.
- Full: at count == DEPTH, apu_req_o is forced low even if a pop occurs in the same cycle. The lock is kept.
- Response routing: on apu_valid_i, the destination is the FIFO head if count != 0.
- Bypass: if count == 0, apu_valid_i and accept occur in the same cycle, this is a zero-latency op.
  - Destination is sel.
  - No FIFO push occurs.
- Push/pop:
  - On accept, the tag sel is pushed, except in the bypass case.
  - On a routed apu_valid_i with count != 0, the head is popped.
  - A push and a pop in the same cycle leave count unchanged. The pointers wrap modulo DEPTH.
- core_valid_o[dest] = apu_valid_i for a routed response. core_result_o = apu_result_i, combinational.
- Orphan: if apu_valid_i with count == 0 and no accept, no core_valid_o is raised and err_o is set. err_o holds until reset.
- busy_o = (count != 0).

## Timing
- Request path (core_req_i/payload → apu_req_o/payload) and grant path (apu_gnt_i → core_gnt_o) are combinational: zero-cycle latency.
- Response path (apu_valid_i → core_valid_o) is combinational. The FIFO head and count update on the next clk_i edge.
- Reset values:
  - All outputs 0.
  - rr = 0, lock = 0, count = 0, FIFO pointers = 0, err = 0.
- Reset mid-operation discards all outstanding tags. Results arriving after reset are orphans and set err_o.
- Throughput: one accept per cycle when the APU grants and the FIFO is not full.

## Test plan
- Single request: core 2 raises req, apu_gnt_i=1 same cycle → core_gnt_o=4'b0100, count 1. Two cycles later apu_valid_i with result 0xCAFE → core_valid_o=4'b0100, core_result_o=0xCAFE, count 0.
- Round-robin: all four cores hold req, APU always grants → grants in order 0,1,2,3,0. After reset, the first grant goes to core 0.
- Lock: cores 1 and 3 request, rr=2, apu_gnt_i=0 for 3 cycles, then core 2 raises req, then gnt=1 → core 3 is granted (not core 2), then rr=0.
- Full: 4 accepts with no returns → apu_req_o=0 while count=4. A return in the same cycle as a pending request still blocks the grant. The grant resumes the next cycle.
- In-order routing and bypass:
  - Accepts from cores 1, 0, 3; returns A, B, C → core 1 gets A, core 0 gets B, core 3 gets C.
  - With count=0, an accept for core 2 with apu_valid_i in the same cycle → core_valid_o=4'b0100, count stays 0.
- Orphan: apu_valid_i with count=0 and no request → core_valid_o=0, err_o=1, held until rst_ni is asserted mid-run. After reset, err_o=0 and busy_o=0.
